// File: rtl/bridge_sram_axi_mp.sv
// Multi-port SRAM-like to AXI3 bridge: round-robin arbitration across NPORT masters,
// per-port read-outstanding limits and read-after-write word hazard blocking.
module bridge_sram_axi_mp #(
   parameter int NPORT    = 2,
   parameter int RD_OUTST = 2
) (
   input  logic                aclk,
   input  logic                areset,
   input  logic [NPORT-1:0]    sram_req,
   input  logic [NPORT-1:0]    sram_wr,
   input  logic [2*NPORT-1:0]  sram_size,
   input  logic [32*NPORT-1:0] sram_addr,
   input  logic [4*NPORT-1:0]  sram_wstrb,
   input  logic [32*NPORT-1:0] sram_wdata,
   output logic [NPORT-1:0]    sram_addr_ok,
   output logic [NPORT-1:0]    sram_data_ok,
   output logic [32*NPORT-1:0] sram_rdata,
   output logic [3:0]          arid,
   output logic [31:0]         araddr,
   output logic [7:0]          arlen,
   output logic [2:0]          arsize,
   output logic [1:0]          arburst,
   output logic [1:0]          arlock,
   output logic [3:0]          arcache,
   output logic [2:0]          arprot,
   output logic                arvalid,
   input  logic                arready,
   input  logic [3:0]          rid,
   input  logic [31:0]         rdata,
   input  logic [1:0]          rresp,
   input  logic                rlast,
   input  logic                rvalid,
   output logic                rready,
   output logic [3:0]          awid,
   output logic [31:0]         awaddr,
   output logic [7:0]          awlen,
   output logic [2:0]          awsize,
   output logic [1:0]          awburst,
   output logic [1:0]          awlock,
   output logic [3:0]          awcache,
   output logic [2:0]          awprot,
   output logic                awvalid,
   input  logic                awready,
   output logic [3:0]          wid,
   output logic [31:0]         wdata,
   output logic [3:0]          wstrb,
   output logic                wlast,
   output logic                wvalid,
   input  logic                wready,
   input  logic [3:0]          bid,
   input  logic [1:0]          bresp,
   input  logic                bvalid,
   output logic                bready
);

   localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

   typedef enum logic {AR_IDLE, AR_REQ} ar_state_t;
   typedef enum logic [1:0] {W_IDLE, W_AD, W_B} w_state_t;

   ar_state_t       ar_state, ar_next;
   w_state_t        w_state, w_next;
   logic [PW-1:0]   rr_ptr;
   logic [2:0]      rd_cnt [NPORT];
   logic            rd_busy;
   logic [NPORT-1:0] elig_rd, elig_wr;
   logic            gnt_valid, gnt_wr;
   logic [PW-1:0]   gnt;
   logic [31:0]     sel_addr, sel_wdata;
   logic [1:0]      sel_size;
   logic [3:0]      sel_wstrb;
   logic            aw_done, w_done;

   assign arlen   = 8'd0;
   assign arburst = 2'b01;
   assign arlock  = 2'b00;
   assign arcache = 4'd0;
   assign arprot  = 3'd0;
   assign awlen   = 8'd0;
   assign awburst = 2'b01;
   assign awlock  = 2'b00;
   assign awcache = 4'd0;
   assign awprot  = 3'd0;
   assign wlast   = 1'b1;
   assign arvalid = (ar_state == AR_REQ);
   assign bready  = (w_state == W_B);
   assign aw_done = !awvalid || awready;
   assign w_done  = !wvalid || wready;

   // A read is held off while a write to the same 32-bit word has not yet been acknowledged.
   always_comb begin
      rd_busy = 1'b0;
      elig_rd = '0;
      elig_wr = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (rd_cnt[p] != 3'd0) rd_busy = 1'b1;
      end
      for (int p = 0; p < NPORT; p++) begin
         elig_rd[p] = sram_req[p] && !sram_wr[p] && (ar_state == AR_IDLE)
                      && (rd_cnt[p] < 3'(RD_OUTST))
                      && !((w_state != W_IDLE) && (sram_addr[p*32+2 +: 30] == awaddr[31:2]));
         elig_wr[p] = sram_req[p] && sram_wr[p] && (w_state == W_IDLE) && !rd_busy;
      end
   end

   // Round-robin search: first the ports at or above the pointer, then wrap to the low ones.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_wr    = 1'b0;
      gnt       = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (!gnt_valid && (p >= int'(rr_ptr)) && (elig_rd[p] || elig_wr[p])) begin
            gnt_valid = 1'b1;
            gnt       = PW'(p);
            gnt_wr    = elig_wr[p];
         end
      end
      for (int p = 0; p < NPORT; p++) begin
         if (!gnt_valid && (p < int'(rr_ptr)) && (elig_rd[p] || elig_wr[p])) begin
            gnt_valid = 1'b1;
            gnt       = PW'(p);
            gnt_wr    = elig_wr[p];
         end
      end
   end

   always_comb begin
      sel_addr     = '0;
      sel_wdata    = '0;
      sel_size     = '0;
      sel_wstrb    = '0;
      sram_addr_ok = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (gnt == PW'(p)) begin
            sel_addr  = sram_addr[p*32 +: 32];
            sel_wdata = sram_wdata[p*32 +: 32];
            sel_size  = sram_size[p*2 +: 2];
            sel_wstrb = sram_wstrb[p*4 +: 4];
            sram_addr_ok[p] = gnt_valid && !areset;
         end
      end
   end

   // Responses are routed by ID; IDs beyond the port count are simply swallowed.
   always_comb begin
      sram_data_ok = '0;
      sram_rdata   = '0;
      for (int p = 0; p < NPORT; p++) begin
         if (rvalid && rready && (rid == 4'(p))) begin
            sram_data_ok[p]       = 1'b1;
            sram_rdata[p*32 +: 32] = rdata;
         end
         if ((w_state == W_B) && bvalid && (bid == 4'(p))) begin
            sram_data_ok[p] = 1'b1;
         end
      end
   end

   always_comb begin
      ar_next = ar_state;
      w_next  = w_state;
      case (ar_state)
         AR_IDLE: if (gnt_valid && !gnt_wr) ar_next = AR_REQ;
         AR_REQ:  if (arready) ar_next = AR_IDLE;
         default: ar_next = AR_IDLE;
      endcase
      case (w_state)
         W_IDLE:  if (gnt_valid && gnt_wr) w_next = W_AD;
         W_AD:    if (aw_done && w_done) w_next = W_B;
         W_B:     if (bvalid) w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         ar_state <= AR_IDLE;
         w_state  <= W_IDLE;
         rr_ptr   <= '0;
         rready   <= 1'b0;
         arid     <= '0;
         araddr   <= '0;
         arsize   <= '0;
         awid     <= '0;
         wid      <= '0;
         awaddr   <= '0;
         awsize   <= '0;
         wdata    <= '0;
         wstrb    <= '0;
         awvalid  <= 1'b0;
         wvalid   <= 1'b0;
         for (int p = 0; p < NPORT; p++) rd_cnt[p] <= 3'd0;
      end else begin
         ar_state <= ar_next;
         w_state  <= w_next;
         rready   <= 1'b1;
         if (gnt_valid) begin
            rr_ptr <= (gnt == PW'(NPORT-1)) ? '0 : gnt + PW'(1);
         end
         if (gnt_valid && !gnt_wr) begin
            araddr <= sel_addr;
            arsize <= {1'b0, sel_size};
            arid   <= 4'(gnt);
         end
         if (gnt_valid && gnt_wr) begin
            awaddr  <= sel_addr;
            awsize  <= {1'b0, sel_size};
            wdata   <= sel_wdata;
            wstrb   <= sel_wstrb;
            awid    <= 4'(gnt);
            wid     <= 4'(gnt);
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
         end else if (w_state == W_AD) begin
            if (awready) awvalid <= 1'b0;
            if (wready)  wvalid  <= 1'b0;
         end
         for (int p = 0; p < NPORT; p++) begin
            case ({gnt_valid && !gnt_wr && (gnt == PW'(p)),
                   rvalid && rready && rlast && (rid == 4'(p))})
               2'b10:   rd_cnt[p] <= rd_cnt[p] + 3'd1;
               2'b01:   rd_cnt[p] <= rd_cnt[p] - 3'd1;
               default: rd_cnt[p] <= rd_cnt[p];
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bridge_sram_axi_mp.sv
// Directed bench for bridge_sram_axi_mp (NPORT=2, RD_OUTST=2): reset, single read,
// round-robin and outstanding limit, write, hazard blocking, write-after-read, mid-run reset.
module tb_bridge_sram_axi_mp;

   localparam int NPORT    = 2;
   localparam int RD_OUTST = 2;

   logic                aclk = 1'b0;
   logic                areset = 1'b1;
   logic [NPORT-1:0]    sram_req;
   logic [NPORT-1:0]    sram_wr;
   logic [2*NPORT-1:0]  sram_size;
   logic [32*NPORT-1:0] sram_addr;
   logic [4*NPORT-1:0]  sram_wstrb;
   logic [32*NPORT-1:0] sram_wdata;
   logic [NPORT-1:0]    sram_addr_ok;
   logic [NPORT-1:0]    sram_data_ok;
   logic [32*NPORT-1:0] sram_rdata;
   logic [3:0]  arid, awid, wid, rid, bid;
   logic [31:0] araddr, awaddr, wdata, rdata;
   logic [7:0]  arlen, awlen;
   logic [2:0]  arsize, awsize, arprot, awprot;
   logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
   logic [3:0]  arcache, awcache, wstrb;
   logic arvalid, arready, rlast, rvalid, rready;
   logic awvalid, awready, wlast, wvalid, wready, bvalid, bready;

   int tests = 0;
   int fails = 0;

   always #5 aclk = ~aclk;

   bridge_sram_axi_mp #(.NPORT(NPORT), .RD_OUTST(RD_OUTST)) dut (
      .aclk(aclk), .areset(areset),
      .sram_req(sram_req), .sram_wr(sram_wr), .sram_size(sram_size),
      .sram_addr(sram_addr), .sram_wstrb(sram_wstrb), .sram_wdata(sram_wdata),
      .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok), .sram_rdata(sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
   );

   task automatic tick;
      @(posedge aclk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   task automatic clear_inputs;
      sram_req = '0; sram_wr = '0; sram_size = '0; sram_addr = '0;
      sram_wstrb = '0; sram_wdata = '0;
      arready = 0; awready = 0; wready = 0;
      rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
      bid = '0; bresp = '0; bvalid = 0;
   endtask

   task automatic set_port(input int p, input logic req, input logic wr, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
      sram_req[p] = req;
      sram_wr[p]  = wr;
      sram_size[2*p +: 2]   = 2'd2;
      sram_addr[32*p +: 32] = addr;
      sram_wstrb[4*p +: 4]  = be;
      sram_wdata[32*p +: 32] = wd;
   endtask

   task automatic r_beat(input logic [3:0] id, input logic [31:0] d);
      rvalid = 1; rid = id; rdata = d; rlast = 1;
   endtask

   task automatic do_reset;
      clear_inputs();
      areset = 1;
      tick(); tick();
      areset = 0;
      tick();
   endtask

   task automatic test_reset;
      clear_inputs();
      tick();
      settle();
      tests++;
      if ({arvalid, awvalid, wvalid, bready, rready} !== 5'b0) begin
         fails++; $display("[TB] FAIL reset_valids: got %b expected 00000", {arvalid, awvalid, wvalid, bready, rready});
      end
      tests++;
      if (sram_addr_ok !== 2'b00 || sram_data_ok !== 2'b00) begin
         fails++; $display("[TB] FAIL reset_ok: got %b/%b expected 00/00", sram_addr_ok, sram_data_ok);
      end
      tests++;
      if (sram_rdata !== 64'd0) begin
         fails++; $display("[TB] FAIL reset_rdata: got %h expected 0", sram_rdata);
      end
      areset = 0;
      tick();
      tests++;
      if (rready !== 1'b1) begin
         fails++; $display("[TB] FAIL rready_after_reset: got %b expected 1", rready);
      end
   endtask

   task automatic test_single_read;
      set_port(0, 1, 0, 32'h1c000000, 4'h0, 32'h0);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL read_addr_ok: got %b expected 01", sram_addr_ok);
      end
      tick();
      set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
      arready = 0;
      settle();
      tests++;
      if (arvalid !== 1 || araddr !== 32'h1c000000 || arid !== 4'd0 || arsize !== 3'd2) begin
         fails++; $display("[TB] FAIL ar_fields: got v=%b a=%h id=%0d sz=%0d expected v=1 a=1c000000 id=0 sz=2",
                           arvalid, araddr, arid, arsize);
      end
      tests++;
      if (sram_addr_ok !== 2'b00 || dut.rd_cnt[0] !== 3'd1) begin
         fails++; $display("[TB] FAIL read_grant_once: got ok=%b cnt=%0d expected ok=00 cnt=1", sram_addr_ok, dut.rd_cnt[0]);
      end
      tick();
      settle();
      tests++;
      if (arvalid !== 1) begin
         fails++; $display("[TB] FAIL arvalid_hold: got %b expected 1", arvalid);
      end
      tick();
      arready = 1;
      settle();
      tests++;
      if (arvalid !== 1) begin
         fails++; $display("[TB] FAIL arvalid_at_ready: got %b expected 1", arvalid);
      end
      tick();
      arready = 0;
      r_beat(4'd0, 32'hDEADBEEF);
      settle();
      tests++;
      if (arvalid !== 0 || sram_data_ok !== 2'b01 || sram_rdata[31:0] !== 32'hDEADBEEF) begin
         fails++; $display("[TB] FAIL read_data: got v=%b ok=%b d=%h expected v=0 ok=01 d=deadbeef",
                           arvalid, sram_data_ok, sram_rdata[31:0]);
      end
      tick();
      rvalid = 0;
      settle();
      tests++;
      if (dut.rd_cnt[0] !== 3'd0 || sram_data_ok !== 2'b00) begin
         fails++; $display("[TB] FAIL read_drain: got cnt=%0d ok=%b expected cnt=0 ok=00", dut.rd_cnt[0], sram_data_ok);
      end
   endtask

   task automatic test_round_robin;
      logic [1:0] exp_ok [10];
      logic [3:0] exp_id [10];
      logic [3:0] beat_id [4];
      exp_ok = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00};
      exp_id = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0};
      beat_id = '{4'd0, 4'd1, 4'd0, 4'd1};
      do_reset();
      arready = 1;
      set_port(0, 1, 0, 32'h1000, 4'h0, 32'h0);
      set_port(1, 1, 0, 32'h2000, 4'h0, 32'h0);
      for (int i = 0; i < 10; i++) begin
         settle();
         tests++;
         if (sram_addr_ok !== exp_ok[i]) begin
            fails++; $display("[TB] FAIL rr_grant[%0d]: got %b expected %b", i, sram_addr_ok, exp_ok[i]);
         end
         if (i % 2 == 1 && i < 8) begin
            tests++;
            if (arvalid !== 1 || arid !== exp_id[i]) begin
               fails++; $display("[TB] FAIL rr_arid[%0d]: got v=%b id=%0d expected v=1 id=%0d", i, arvalid, arid, exp_id[i]);
            end
         end
         tick();
      end
      clear_inputs();
      tests++;
      if (dut.rd_cnt[0] !== 3'd2 || dut.rd_cnt[1] !== 3'd2) begin
         fails++; $display("[TB] FAIL rr_limit: got %0d/%0d expected 2/2", dut.rd_cnt[0], dut.rd_cnt[1]);
      end
      for (int i = 0; i < 4; i++) begin
         r_beat(beat_id[i], 32'hA0 + i);
         settle();
         tests++;
         if (sram_data_ok !== (2'b01 << beat_id[i]) || sram_rdata[32*beat_id[i] +: 32] !== 32'hA0 + i) begin
            fails++; $display("[TB] FAIL rr_beat[%0d]: got ok=%b d=%h expected ok=%b d=%h", i, sram_data_ok,
                              sram_rdata[32*beat_id[i] +: 32], 2'b01 << beat_id[i], 32'hA0 + i);
         end
         tick();
      end
      rvalid = 0;
      settle();
      tests++;
      if (dut.rd_cnt[0] !== 3'd0 || dut.rd_cnt[1] !== 3'd0) begin
         fails++; $display("[TB] FAIL rr_drain: got %0d/%0d expected 0/0", dut.rd_cnt[0], dut.rd_cnt[1]);
      end
   endtask

   task automatic test_write;
      int aw_hs = 0;
      int w_hs = 0;
      set_port(1, 1, 1, 32'h100, 4'h3, 32'h1234);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL write_addr_ok: got %b expected 10", sram_addr_ok);
      end
      tick();
      set_port(1, 0, 0, 32'h0, 4'h0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         awready = (c == 0);
         wready  = (c == 3);
         settle();
         if (c == 0) begin
            tests++;
            if (awvalid !== 1 || wvalid !== 1 || awaddr !== 32'h100 || awid !== 4'd1 || wid !== 4'd1 ||
                wdata !== 32'h1234 || wstrb !== 4'h3 || awsize !== 3'd2 || wlast !== 1) begin
               fails++; $display("[TB] FAIL write_fields: got av=%b wv=%b a=%h awid=%0d wid=%0d d=%h s=%h sz=%0d expected 1 1 100 1 1 1234 3 2",
                                 awvalid, wvalid, awaddr, awid, wid, wdata, wstrb, awsize);
            end
         end
         if (awvalid && awready) aw_hs++;
         if (wvalid && wready) w_hs++;
         tick();
      end
      awready = 0; wready = 0;
      settle();
      tests++;
      if (aw_hs != 1 || w_hs != 1 || bready !== 1 || awvalid !== 0 || wvalid !== 0) begin
         fails++; $display("[TB] FAIL write_beats: got aw=%0d w=%0d bready=%b expected 1 1 1", aw_hs, w_hs, bready);
      end
      bvalid = 1; bid = 4'd1;
      settle();
      tests++;
      if (sram_data_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL write_data_ok: got %b expected 10", sram_data_ok);
      end
      tick();
      bvalid = 0;
      settle();
      tests++;
      if (sram_data_ok !== 2'b00 || bready !== 0) begin
         fails++; $display("[TB] FAIL write_done: got ok=%b bready=%b expected 00 0", sram_data_ok, bready);
      end
   endtask

   task automatic test_hazard;
      set_port(1, 1, 1, 32'h100, 4'hF, 32'h5555);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL hz_write_grant: got %b expected 10", sram_addr_ok);
      end
      tick();
      set_port(1, 0, 0, 32'h0, 4'h0, 32'h0);
      set_port(0, 1, 0, 32'h102, 4'h0, 32'h0);
      for (int c = 0; c < 4; c++) begin
         awready = (c == 3);
         wready  = (c == 3);
         settle();
         tests++;
         if (sram_addr_ok !== 2'b00) begin
            fails++; $display("[TB] FAIL hz_blocked[%0d]: got %b expected 00", c, sram_addr_ok);
         end
         tick();
      end
      awready = 0; wready = 0;
      bvalid = 1; bid = 4'd1;
      settle();
      tests++;
      if (sram_addr_ok !== 2'b00 || sram_data_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL hz_at_b: got ok=%b dok=%b expected 00 10", sram_addr_ok, sram_data_ok);
      end
      tick();
      bvalid = 0;
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL hz_released: got %b expected 01", sram_addr_ok);
      end
      tick();
      set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
      arready = 1;
      tick();
      arready = 0;
      r_beat(4'd0, 32'h11);
      tick();
      rvalid = 0;
      set_port(1, 1, 1, 32'h100, 4'hF, 32'h6666);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL hz_write2_grant: got %b expected 10", sram_addr_ok);
      end
      tick();
      set_port(1, 0, 0, 32'h0, 4'h0, 32'h0);
      set_port(0, 1, 0, 32'h104, 4'h0, 32'h0);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL hz_other_word: got %b expected 01", sram_addr_ok);
      end
      tick();
      set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
      arready = 1; awready = 1; wready = 1;
      tick();
      arready = 0; awready = 0; wready = 0;
      bvalid = 1; bid = 4'd1;
      r_beat(4'd0, 32'h55);
      settle();
      tests++;
      if (sram_data_ok !== 2'b11 || sram_rdata[31:0] !== 32'h55) begin
         fails++; $display("[TB] FAIL hz_both_resp: got ok=%b d=%h expected 11 55", sram_data_ok, sram_rdata[31:0]);
      end
      tick();
      bvalid = 0; rvalid = 0;
      settle();
      tests++;
      if (dut.rd_cnt[0] !== 3'd0 || bready !== 0) begin
         fails++; $display("[TB] FAIL hz_idle: got cnt=%0d bready=%b expected 0 0", dut.rd_cnt[0], bready);
      end
   endtask

   task automatic test_write_after_read;
      set_port(0, 1, 0, 32'h200, 4'h0, 32'h0);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL war_read_grant: got %b expected 01", sram_addr_ok);
      end
      tick();
      set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
      set_port(1, 1, 1, 32'h300, 4'hF, 32'hCAFE);
      arready = 1;
      for (int c = 0; c < 2; c++) begin
         settle();
         tests++;
         if (sram_addr_ok !== 2'b00) begin
            fails++; $display("[TB] FAIL war_blocked[%0d]: got %b expected 00", c, sram_addr_ok);
         end
         tick();
         arready = 0;
      end
      r_beat(4'd0, 32'h22);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b00 || sram_data_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL war_at_rlast: got ok=%b dok=%b expected 00 01", sram_addr_ok, sram_data_ok);
      end
      tick();
      rvalid = 0;
      settle();
      tests++;
      if (sram_addr_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL war_granted: got %b expected 10", sram_addr_ok);
      end
      tick();
      set_port(1, 0, 0, 32'h0, 4'h0, 32'h0);
      awready = 1; wready = 1;
      tick();
      awready = 0; wready = 0;
      bvalid = 1; bid = 4'd1;
      settle();
      tests++;
      if (sram_data_ok !== 2'b10) begin
         fails++; $display("[TB] FAIL war_bresp: got %b expected 10", sram_data_ok);
      end
      tick();
      bvalid = 0;
   endtask

   task automatic test_reset_mid;
      set_port(0, 1, 0, 32'h400, 4'h0, 32'h0);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL mid_grant1: got %b expected 01", sram_addr_ok);
      end
      tick();
      arready = 1;
      tick();
      arready = 0;
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01) begin
         fails++; $display("[TB] FAIL mid_grant2: got %b expected 01", sram_addr_ok);
      end
      tick();
      set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
      settle();
      tests++;
      if (arvalid !== 1 || dut.rd_cnt[0] !== 3'd2 || dut.rr_ptr !== 1'b1) begin
         fails++; $display("[TB] FAIL mid_pre: got v=%b cnt=%0d ptr=%0d expected 1 2 1", arvalid, dut.rd_cnt[0], dut.rr_ptr);
      end
      areset = 1;
      #1;
      tests++;
      if (arvalid !== 0 || dut.rd_cnt[0] !== 3'd0 || dut.rr_ptr !== 1'b0 || rready !== 0) begin
         fails++; $display("[TB] FAIL mid_async: got v=%b cnt=%0d ptr=%0d rready=%b expected 0 0 0 0",
                           arvalid, dut.rd_cnt[0], dut.rr_ptr, rready);
      end
      tick();
      areset = 0;
      tick();
      set_port(0, 1, 0, 32'h500, 4'h0, 32'h0);
      settle();
      tests++;
      if (sram_addr_ok !== 2'b01 || rready !== 1) begin
         fails++; $display("[TB] FAIL mid_resume: got ok=%b rready=%b expected 01 1", sram_addr_ok, rready);
      end
      tick();
      set_port(0, 0, 0, 32'h0, 4'h0, 32'h0);
      arready = 1;
      tick();
      arready = 0;
      r_beat(4'd0, 32'h77);
      settle();
      tests++;
      if (sram_data_ok !== 2'b01 || sram_rdata[31:0] !== 32'h77) begin
         fails++; $display("[TB] FAIL mid_rdata: got ok=%b d=%h expected 01 77", sram_data_ok, sram_rdata[31:0]);
      end
      tick();
      rvalid = 0;
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      clear_inputs();
      test_reset();
      test_single_read();
      test_round_robin();
      test_write();
      test_hazard();
      test_write_after_read();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bridge_sram_axi_mp.md
Name: bridge_sram_axi_mp

Overview:
- Multi-port successor to the two-port SRAM-like-to-AXI3 bridge.
- Serves NPORT SRAM-like masters (port 0 = IF, port 1 = EX/MEM; more for future TLB/cache refill) on one AXI master interface.
- Adds round-robin arbitration, per-port read-outstanding limits, and read-after-write address hazard blocking.
- Sits between the pipeline stages and the AXI interconnect inside mycpu_top.

Parameters:
NPORT, 2, number of SRAM-like ports (1..16; port index drives AXI ID)
RD_OUTST, 2, max outstanding reads per port (1..7)

Ports:
aclk  in  1  clock
areset  in  1  asynchronous active-high reset
sram_req  in  NPORT  request per port
sram_wr  in  NPORT  1 = write
sram_size  in  2*NPORT  bytes = 1<<size, port p at [2p+1:2p]
sram_addr  in  32*NPORT  byte address
sram_wstrb  in  4*NPORT  write byte enables
sram_wdata  in  32*NPORT  write data
sram_addr_ok  out  NPORT  request accepted
sram_data_ok  out  NPORT  read data valid / write completed
sram_rdata  out  32*NPORT  read data
arid,araddr,arsize,arvalid  out  4,32,3,1  AR channel; arready in 1
rid,rdata,rresp,rlast,rvalid  in  4,32,2,1,1  R channel; rready out 1
awid,awaddr,awsize,awvalid  out  4,32,3,1  AW channel; awready in 1
wid,wdata,wstrb,wlast,wvalid  out  4,32,4,1,1  W channel; wready in 1
bid,bresp,bvalid  in  4,2,1  B channel; bready out 1
arlen/awlen(8)=0, arburst/awburst(2)=2'b01, arlock/awlock(2)=0, arcache/awcache(4)=0, arprot/awprot(3)=0, wlast=1  out  constant

Behaviour:
- Reset:
  - All valids 0, bready 0, rready 0.
  - sram_addr_ok and sram_data_ok 0; sram_rdata 0.
  - All rd_cnt[p] = 0; round-robin pointer = 0.
  - AR FSM = AR_IDLE; W FSM = W_IDLE.
  - The first edge after areset falls sets rready = 1 and holds it at 1.
- Eligibility:
  - Read from port p: req & !wr & AR_IDLE & rd_cnt[p] < RD_OUTST & !(W FSM not W_IDLE & addr[31:2] == latched awaddr[31:2]).
  - Write from port p: req & wr & W_IDLE & sum of rd_cnt == 0.
- Arbitration:
  - One grant per cycle, round-robin starting at the pointer, across reads and writes.
  - On grant to port g: pointer <= (g+1) mod NPORT, and sram_addr_ok[g] = 1 combinationally in that cycle.
  - A request that is not granted sees addr_ok = 0 and must hold its request.
- AR FSM:
  - AR_IDLE --grant read--> AR_REQ: latch araddr = addr, arsize = {0,size}, arid = g; arvalid = 1.
  - AR_REQ --arready--> AR_IDLE.
  - rd_cnt[g] increments on grant.
- R path:
  - For rvalid & rid < NPORT: sram_data_ok[rid] = 1 and sram_rdata[rid] = rdata, same cycle, combinational.
  - rd_cnt[rid] decrements on rvalid & rlast.
  - Simultaneous increment and decrement on the same port leaves the count unchanged.
  - rid >= NPORT: beat accepted and dropped.
  - rresp is ignored.
- W FSM:
  - W_IDLE --grant write--> W_AD: latch awaddr = addr, awsize, wdata, wstrb, awid = wid = g; awvalid = wvalid = 1.
  - In W_AD, awvalid and wvalid drop independently on their own handshakes. When both are done (either may occur first, or both in the same cycle) --> W_B with bready = 1.
  - W_B --bvalid--> W_IDLE: sram_data_ok[bid] = 1 for that cycle; bready = 0.
- Ordering:
  - Reads are never issued to a word with a write in flight.
  - Writes wait until all reads have drained.
  - Per-port responses are in order because each port uses a single AXI ID.
- Reset mid-operation: all state is dropped; the AXI slave is reset by the same source.

Test Plan:
- Port 0 read 0x1c000000 with arready held 2 cycles -> addr_ok[0] 1 cycle; arvalid stays 1 until arready; arid=0, arsize=2; rvalid with rid=0, rdata=0xDEADBEEF -> data_ok[0]=1, rdata[0]=0xDEADBEEF; rd_cnt[0] back to 0.
- Ports 0 and 1 reading every cycle, NPORT=2 -> grants alternate 0,1,0,1; with RD_OUTST=2 and no R beats, each port blocks after 2 grants.
- Port 1 writes 0x100 (wstrb=0x3, wdata=0x1234); wready arrives 3 cycles after awready -> one AW and one W beat with wid=1; bvalid -> data_ok[1] exactly 1 cycle.
- Write to 0x100 in flight plus port 0 read of 0x102 -> read held (addr_ok 0) until the B handshake; a read to 0x104 in the same situation is granted immediately.
- Write request while rd_cnt[0]=1 -> write blocked until the rlast beat; then granted the next cycle.
- areset asserted with arvalid=1 and rd_cnt=2 -> arvalid, rd_cnt, pointer and rready are 0 immediately (asynchronously); normal operation resumes after release.
